// File: rtl/kf_pkg.sv
// -----------------------------------------------------------------------------
// kf_pkg
// Shared types, defaults and helpers for the measurement-conditioning stage
// that sits in front of kalman_filter.
//
// Contents:
//   KF_SAMPLE_W, KF_Z_W, KF_LOG2_N, KF_OVF_CNT_W, KF_TIMEOUT_CYC
//                     default parameter values for the conditioner
//   kf_cond_state_t   issue FSM state (IDLE, WAIT)
//   sat_signed()      clamp a signed value into a 'width'-bit signed range
// -----------------------------------------------------------------------------
package kf_pkg;

  localparam int KF_SAMPLE_W    = 16;
  localparam int KF_Z_W         = 16;
  localparam int KF_LOG2_N      = 2;
  localparam int KF_OVF_CNT_W   = 8;
  localparam int KF_TIMEOUT_CYC = 64;

  // IDLE: free to issue the pending average.
  // WAIT: a measurement is outstanding in the filter.
  typedef enum logic {
    IDLE,
    WAIT
  } kf_cond_state_t;

  // Clamp 'value' to [-(2^(width-1)), 2^(width-1)-1]. The caller narrows the
  // 64-bit result back to 'width' bits, which is lossless after the clamp.
  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] value,
    input int unsigned        width
  );
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage : kf_pkg

// File: rtl/kf_boxcar_avg.sv
// -----------------------------------------------------------------------------
// kf_boxcar_avg
// Boxcar averager: sums 2^LOG2_N consecutive valid samples and produces their
// floor-mean, saturated to Z_W bits.
//
// The average is presented combinationally in the same cycle as the Nth
// sample, so the parent can capture it at that edge. This keeps the path
// "Nth sample in cycle t -> pending register at t+1" to a single register.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset (drops any partial sum)
//   i_s_data     in   raw signed sample
//   i_s_valid    in   i_s_data valid this cycle (always accepted)
//   o_avg_data   out  saturated floor-mean of the window (valid with strobe)
//   o_avg_valid  out  one-cycle strobe, high in the cycle of the Nth sample
// -----------------------------------------------------------------------------
module kf_boxcar_avg
  import kf_pkg::*;
#(
  parameter int SAMPLE_W = KF_SAMPLE_W,
  parameter int Z_W      = KF_Z_W,
  parameter int LOG2_N   = KF_LOG2_N
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] i_s_data,
  input  logic                       i_s_valid,
  output logic signed [Z_W-1:0]      o_avg_data,
  output logic                       o_avg_valid
);

  // LOG2_N guard bits make the N-sample sum overflow-free.
  localparam int ACC_W = SAMPLE_W + LOG2_N;

  logic signed [ACC_W-1:0]  r_acc;
  logic        [LOG2_N-1:0] r_cnt;

  logic signed [ACC_W-1:0]  w_sample_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_mean;
  logic                     w_last;

  // NOTE: every signal written in always_comb gets a value on every path
  // (here simply assigned unconditionally); a missing default infers a latch.
  always_comb begin
    w_sample_ext = $signed({{LOG2_N{i_s_data[SAMPLE_W-1]}}, i_s_data});
    w_sum        = r_acc + w_sample_ext;
    // Arithmetic shift of a signed value rounds toward -infinity.
    w_mean       = w_sum >>> LOG2_N;
    // r_cnt saturated at all-ones means this is sample N-1 of the window.
    w_last       = i_s_valid && (&r_cnt);
  end

  assign o_avg_data  = Z_W'(sat_signed(longint'(w_mean), Z_W));
  assign o_avg_valid = w_last;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_s_valid) begin
      if (w_last) begin
        // Window complete: start the next one from zero.
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + LOG2_N'(1);
      end
    end
  end

endmodule : kf_boxcar_avg

// File: rtl/kf_meas_conditioner.sv
// -----------------------------------------------------------------------------
// kf_meas_conditioner
// Upstream stage for kalman_filter. Boxcar-averages the raw sample stream,
// holds at most one pending average, and issues it to the filter as z with a
// one-cycle z_valid strobe whenever the filter is idle. The filter's x_valid
// rising edge marks completion; a filter that never answers is abandoned
// after TIMEOUT_CYC cycles and flagged with a sticky timeout_err.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset; clears all state
//   s_data       in   raw signed sample (SAMPLE_W)
//   s_valid      in   s_data valid; always accepted, no backpressure
//   kf_x_valid   in   filter output-valid; its rising edge means "done"
//   z            out  measurement to the filter (Z_W), held until next issue
//   z_valid      out  one-cycle strobe per issued measurement
//   busy         out  high while a measurement is outstanding (FSM in WAIT)
//   overrun_cnt  out  saturating count of overwritten pending averages
//   timeout_err  out  sticky; set when a filter wait times out
// -----------------------------------------------------------------------------
module kf_meas_conditioner
  import kf_pkg::*;
#(
  parameter int SAMPLE_W    = KF_SAMPLE_W,
  parameter int Z_W         = KF_Z_W,
  parameter int LOG2_N      = KF_LOG2_N,
  parameter int OVF_CNT_W   = KF_OVF_CNT_W,
  parameter int TIMEOUT_CYC = KF_TIMEOUT_CYC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [SAMPLE_W-1:0]  s_data,
  input  logic                        s_valid,
  input  logic                        kf_x_valid,
  output logic signed [Z_W-1:0]       z,
  output logic                        z_valid,
  output logic                        busy,
  output logic        [OVF_CNT_W-1:0] overrun_cnt,
  output logic                        timeout_err
);

  // Timer only has to reach TIMEOUT_CYC-1 before the FSM leaves WAIT.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // ---------------------------------------------------------------------------
  // Averager
  // ---------------------------------------------------------------------------
  logic signed [Z_W-1:0] w_avg_data;
  logic                  w_avg_valid;

  kf_boxcar_avg #(
    .SAMPLE_W (SAMPLE_W),
    .Z_W      (Z_W),
    .LOG2_N   (LOG2_N)
  ) u_boxcar (
    .clk         (clk),
    .reset       (reset),
    .i_s_data    (s_data),
    .i_s_valid   (s_valid),
    .o_avg_data  (w_avg_data),
    .o_avg_valid (w_avg_valid)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  kf_cond_state_t         r_state;
  logic [TMR_W-1:0]       r_timer;
  logic                   r_kf_x_valid_q;

  logic signed [Z_W-1:0]  r_pend_data;
  logic                   r_pend_valid;
  logic [OVF_CNT_W-1:0]   r_overrun_cnt;

  logic signed [Z_W-1:0]  r_z;
  logic                   r_z_valid;
  logic                   r_timeout_err;

  logic                   w_done;
  logic                   w_consume;
  logic                   w_timer_expired;

  // Completion is the rising edge of the filter's output-valid, so a level
  // held high from a previous result never counts as a second done.
  assign w_done          = kf_x_valid & ~r_kf_x_valid_q;

  // The FSM takes the pending entry this cycle; a simultaneous new average
  // refills the slot without counting as an overrun.
  assign w_consume       = (r_state == IDLE) && r_pend_valid;

  assign w_timer_expired = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kf_x_valid_q <= 1'b0;
    end else begin
      r_kf_x_valid_q <= kf_x_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending register and overrun counter
  // ---------------------------------------------------------------------------
  // NOTE: r_pend_data is a plain register, not a memory, so it is reset along
  // with its valid bit; a stale value can never leak into z after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_data   <= '0;
      r_pend_valid  <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      if (w_avg_valid) begin
        // Newest average always wins the slot.
        r_pend_data  <= w_avg_data;
        r_pend_valid <= 1'b1;
        if (r_pend_valid && !w_consume && (r_overrun_cnt != '1)) begin
          r_overrun_cnt <= r_overrun_cnt + OVF_CNT_W'(1);
        end
      end else if (w_consume) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM, wait timer and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_z           <= '0;
      r_z_valid     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_z_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (r_pend_valid) begin
            r_z       <= r_pend_data;
            r_z_valid <= 1'b1;
            r_timer   <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          // A done in the same cycle as expiry takes precedence, so a filter
          // answering on its last allowed cycle is not flagged.
          if (w_done) begin
            r_state <= IDLE;
          end else if (w_timer_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign z           = r_z;
  assign z_valid     = r_z_valid;
  assign busy        = (r_state == WAIT);
  assign overrun_cnt = r_overrun_cnt;
  assign timeout_err = r_timeout_err;

endmodule : kf_meas_conditioner

// File: tb/tb_kf_meas_conditioner.sv
// -----------------------------------------------------------------------------
// tb_kf_meas_conditioner
// Directed self-checking bench for kf_meas_conditioner with default parameters
// (SAMPLE_W=16, Z_W=16, N=4, OVF_CNT_W=8, TIMEOUT_CYC=64). Inputs change 1 ns
// after a rising edge; outputs are inspected at the same point, i.e. they show
// the state loaded by the edge just passed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kf_meas_conditioner;

  logic               clk;
  logic               reset;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               kf_x_valid;
  logic signed [15:0] z;
  logic               z_valid;
  logic               busy;
  logic [7:0]         overrun_cnt;
  logic               timeout_err;

  int total;
  int bad;

  kf_meas_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .kf_x_valid  (kf_x_valid),
    .z           (z),
    .z_valid     (z_valid),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid    = 1'b0;
    s_data     = '0;
    kf_x_valid = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
  endtask

  // Four samples on consecutive cycles; returns in the cycle after the 4th.
  task automatic feed4(input int a, input int b, input int c, input int d);
    int v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      s_data  = 16'(v[i]);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
  endtask

  // One-cycle rise of kf_x_valid, then drop it again.
  task automatic kf_done();
    kf_x_valid = 1'b1;
    tick();
    kf_x_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (z !== 16'sd0 || z_valid !== 1'b0 || busy !== 1'b0 ||
        overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: z=%0d zv=%0b busy=%0b ovf=%0d to=%0b, want all 0",
               z, z_valid, busy, overrun_cnt, timeout_err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    feed4(100, 104, 96, 100);
    total++;
    if (z_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early: z_valid=%0b want 0 one cycle after 4th sample", z_valid);
    end
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_issue: z_valid=%0b z=%0d busy=%0b want 1/100/1", z_valid, z, busy);
    end
    tick();
    total++;
    if (z_valid !== 1'b0 || z !== 16'sd100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold: z_valid=%0b z=%0d busy=%0b want 0/100/1", z_valid, z, busy);
    end
    kf_x_valid = 1'b1;
    tick();
    kf_x_valid = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: busy=%0b want 0 after kf_x_valid rise", busy);
    end
    tick();
  endtask

  task automatic test_neg_rounding();
    do_reset();
    feed4(-1, -2, -2, -2);
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== -16'sd2) begin
      bad++;
      $display("FAIL neg_floor: z_valid=%0b z=%0d want 1/-2", z_valid, z);
    end
    kf_done();
    feed4(-500, -500, -500, -500);
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== -16'sd500) begin
      bad++;
      $display("FAIL neg_500: z_valid=%0b z=%0d want 1/-500", z_valid, z);
    end
    kf_done();
  endtask

  task automatic test_overrun();
    do_reset();
    feed4(1000, 1000, 1000, 1000);
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd1000) begin
      bad++;
      $display("FAIL ovr_first: z_valid=%0b z=%0d want 1/1000", z_valid, z);
    end
    feed4(2000, 2000, 2000, 2000);
    total++;
    if (overrun_cnt !== 8'd0) begin
      bad++;
      $display("FAIL ovr_fill: overrun_cnt=%0d want 0", overrun_cnt);
    end
    feed4(3000, 3000, 3000, 3000);
    total++;
    if (overrun_cnt !== 8'd1) begin
      bad++;
      $display("FAIL ovr_one: overrun_cnt=%0d want 1", overrun_cnt);
    end
    kf_done();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd3000) begin
      bad++;
      $display("FAIL ovr_newest: z_valid=%0b z=%0d want 1/3000", z_valid, z);
    end
    // 400 back-to-back windows with the filter silent: well over 255 overruns
    // even with the timeout periodically draining the slot.
    for (int i = 0; i < 1600; i++) begin
      s_data  = 16'sd5;
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    tick();
    total++;
    if (overrun_cnt !== 8'd255) begin
      bad++;
      $display("FAIL ovr_sat: overrun_cnt=%0d want 255", overrun_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      s_data  = 16'sd5;
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    tick();
    total++;
    if (overrun_cnt !== 8'd255) begin
      bad++;
      $display("FAIL ovr_sat_hold: overrun_cnt=%0d want 255", overrun_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    feed4(10, 10, 10, 10);
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd10) begin
      bad++;
      $display("FAIL to_issue: z_valid=%0b z=%0d want 1/10", z_valid, z);
    end
    // Now in WAIT cycle with timer=0. Queue a second average meanwhile.
    feed4(20, 20, 20, 20);
    for (int i = 0; i < 59; i++) tick();
    // Cycle with timer=63: still waiting.
    total++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_last_wait: busy=%0b timeout_err=%0b want 1/0", busy, timeout_err);
    end
    tick();
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || z_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_expire: busy=%0b timeout_err=%0b z_valid=%0b want 0/1/0",
               busy, timeout_err, z_valid);
    end
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd20 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_next: z_valid=%0b z=%0d timeout_err=%0b want 1/20/1",
               z_valid, z, timeout_err);
    end
    kf_done();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL to_sticky: timeout_err=%0b busy=%0b want 1/0", timeout_err, busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    feed4(50, 50, 50, 50);
    tick();
    feed4(60, 60, 60, 60);
    // Window of 70s: the 4th sample lands in the cycle the FSM consumes 60.
    for (int i = 0; i < 2; i++) begin
      s_data  = 16'sd70;
      s_valid = 1'b1;
      tick();
    end
    s_data     = 16'sd70;
    kf_x_valid = 1'b1;
    tick();
    kf_x_valid = 1'b0;
    tick();
    s_valid    = 1'b0;
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd60 || overrun_cnt !== 8'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sim_issue: z_valid=%0b z=%0d ovf=%0d busy=%0b want 1/60/0/1",
               z_valid, z, overrun_cnt, busy);
    end
    tick();
    total++;
    if (z_valid !== 1'b0) begin
      bad++;
      $display("FAIL sim_pulse: z_valid=%0b want 0", z_valid);
    end
    kf_done();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd70 || overrun_cnt !== 8'd0) begin
      bad++;
      $display("FAIL sim_second: z_valid=%0b z=%0d ovf=%0d want 1/70/0", z_valid, z, overrun_cnt);
    end
    // Now WAIT with timer=0; done edge exactly in the timer=63 cycle.
    for (int i = 0; i < 63; i++) tick();
    kf_x_valid = 1'b1;
    tick();
    kf_x_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL sim_done_wins: busy=%0b timeout_err=%0b want 0/0", busy, timeout_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    s_data  = 16'sd7;
    s_valid = 1'b1;
    tick();
    s_data  = 16'sd9;
    tick();
    s_valid = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    feed4(500, 500, 500, 500);
    tick();
    total++;
    if (z_valid !== 1'b1 || z !== 16'sd500) begin
      bad++;
      $display("FAIL rst_window: z_valid=%0b z=%0d want 1/500", z_valid, z);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || z !== 16'sd0 || z_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait: busy=%0b z=%0d z_valid=%0b want 0/0/0", busy, z, z_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (z_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_quiet: activity=%0b want 0 after reset in WAIT", seen);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    s_data     = '0;
    s_valid    = 1'b0;
    kf_x_valid = 1'b0;
    test_reset();
    test_basic();
    test_neg_rounding();
    test_overrun();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_kf_meas_conditioner
